// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and IF/ID stage register for the ARM-subset pipeline
// Optional FETCH_PERF_EN adds fetch_count/bubble_count performance counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        freeze,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        if_valid
);

  typedef enum logic [1:0] {RUN, HOLD, REDIRECT} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        do_branch;
  logic        do_flush;
  logic        do_fetch;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN, HOLD, REDIRECT: begin
        if (branch_taken)  state_d = REDIRECT;
        else if (flush)    state_d = RUN;
        else if (freeze)   state_d = HOLD;
        else               state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Control decode follows the edge priority branch > flush > freeze > fetch.
  always_comb begin
    imem_address = {2'b00, pc[31:2]};
    pc_plus4     = pc + 32'd4;
    do_branch    = branch_taken;
    do_flush     = !branch_taken && flush;
    do_fetch     = !branch_taken && !flush && !freeze;
  end

  // Bubbles latch NOP_WORD so an undefined read during redirect never reaches decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_PC & ~32'd3;
      if_pc          <= 32'd0;
      if_instruction <= NOP_WORD;
      if_valid       <= 1'b0;
    end else if (do_branch) begin
      pc             <= branch_address & ~32'd3;
      if_instruction <= NOP_WORD;
      if_valid       <= 1'b0;
    end else if (do_flush) begin
      if_instruction <= NOP_WORD;
      if_valid       <= 1'b0;
    end else if (do_fetch) begin
      pc             <= pc_plus4;
      if_pc          <= pc_plus4;
      if_instruction <= imem_instruction;
      if_valid       <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else if (do_branch || do_flush) begin
      bubble_count <= bubble_count + 32'd1;
    end else if (do_fetch) begin
      fetch_count  <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed table-driven bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, freeze, flush, branch_taken;
  logic [31:0] branch_address;
  logic [31:0] imem_address, imem_instruction;
  logic [31:0] if_pc, if_instruction;
  logic        if_valid;
  logic        xmode;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, bubble_count;
  logic [31:0] exp_fetch, exp_bubble;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] idx);
    return 32'hE000_0000 | (idx & 32'h0FFF_FFFF) ^ {idx[29:0], 2'b00};
  endfunction

  assign imem_instruction = xmode ? 32'hxxxx_xxxx : memf(imem_address);

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .freeze(freeze), .flush(flush),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .if_pc(if_pc), .if_instruction(if_instruction),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .if_valid(if_valid)
  );

  typedef struct {
    logic        rst, frz, fl, br;
    logic [31:0] ba;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, f, l, b, input logic [31:0] ba, ea, ep, input logic ev);
    vec_t v;
    v.rst = r; v.frz = f; v.fl = l; v.br = b; v.ba = ba;
    v.e_addr = ea; v.e_pc = ep; v.e_valid = ev;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, f, l, b, input logic [31:0] ba);
    @(negedge clock);
    reset = r; freeze = f; flush = l; branch_taken = b; branch_address = ba;
    @(posedge clock);
    #1;
`ifdef FETCH_PERF_EN
    if (r) begin exp_fetch = 0; exp_bubble = 0; end
    else if (b || l) exp_bubble = exp_bubble + 1;
    else if (!f) exp_fetch = exp_fetch + 1;
`endif
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_address = 32'd0; xmode = 1'b0;
`ifdef FETCH_PERF_EN
    exp_fetch = 0; exp_bubble = 0;
`endif
    //   rst frz fl br  target          addr          if_pc         valid
    add(1, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0);
    add(1, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0);
    add(0, 0, 0, 0, 32'h0,          32'h1,        32'h4,        1);
    add(0, 0, 0, 0, 32'h0,          32'h2,        32'h8,        1);
    add(0, 0, 0, 0, 32'h0,          32'h3,        32'hC,        1);
    for (int i = 4; i <= 9; i++)
      add(0, 0, 0, 0, 32'h0, 32'(i), 32'(4 * i), 1);
    add(0, 0, 0, 1, 32'h1C,         32'h7,        32'h24,       0);
    add(0, 0, 0, 0, 32'h0,          32'h8,        32'h20,       1);
    add(0, 0, 0, 1, 32'h0C,         32'h3,        32'h20,       0);
    add(0, 0, 0, 0, 32'h0,          32'h4,        32'h10,       1);
    add(0, 1, 0, 0, 32'h0,          32'h4,        32'h10,       1);
    add(0, 1, 0, 0, 32'h0,          32'h4,        32'h10,       1);
    add(0, 0, 0, 0, 32'h0,          32'h5,        32'h14,       1);
    add(0, 1, 0, 1, 32'h40,         32'h10,       32'h14,       0);
    add(0, 0, 0, 0, 32'h0,          32'h11,       32'h44,       1);
    add(0, 0, 0, 1, 32'h08,         32'h2,        32'h44,       0);
    add(0, 0, 1, 0, 32'h0,          32'h2,        32'h44,       0);
    add(0, 0, 0, 0, 32'h0,          32'h3,        32'hC,        1);
    add(0, 1, 1, 0, 32'h0,          32'h3,        32'hC,        0);
    add(0, 0, 0, 0, 32'h0,          32'h4,        32'h10,       1);
    add(0, 0, 0, 1, 32'h100,        32'h40,       32'h10,       0);
    add(0, 0, 0, 1, 32'h200,        32'h80,       32'h10,       0);
    add(0, 0, 0, 0, 32'h0,          32'h81,       32'h204,      1);
    add(0, 0, 0, 1, 32'h33,         32'hC,        32'h204,      0);
    add(0, 0, 0, 0, 32'h0,          32'hD,        32'h34,       1);
    add(0, 0, 0, 1, 32'hFFFF_FFFF,  32'h3FFF_FFFF, 32'h34,      0);
    add(0, 0, 0, 0, 32'h0,          32'h0,        32'h0,        1);
    add(0, 0, 0, 0, 32'h0,          32'h1,        32'h4,        1);
    add(1, 0, 0, 0, 32'h0,          32'h0,        32'h0,        0);

    foreach (vecs[i]) begin
      logic [31:0] e_instr;
      step(vecs[i].rst, vecs[i].frz, vecs[i].fl, vecs[i].br, vecs[i].ba);
      e_instr = vecs[i].e_valid ? memf((vecs[i].e_pc - 32'd4) >> 2) : NOP;
      check32($sformatf("v%0d imem_address", i), imem_address, vecs[i].e_addr);
      check32($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      check32($sformatf("v%0d if_instruction", i), if_instruction, e_instr);
      if (vecs[i].e_valid || vecs[i].rst)
        check32($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
`ifdef FETCH_PERF_EN
      check32($sformatf("v%0d fetch_count", i), fetch_count, exp_fetch);
      check32($sformatf("v%0d bubble_count", i), bubble_count, exp_bubble);
`endif
    end

    // Undefined read data during a redirect bubble and a flush must latch NOP.
    step(0, 0, 0, 0, 32'h0);
    check32("pre_x if_valid", {31'd0, if_valid}, 32'd1);
    xmode = 1'b1;
    step(0, 0, 0, 1, 32'h80);
    check32("x_branch if_instruction", if_instruction, NOP);
    check32("x_branch imem_address", imem_address, 32'h20);
    step(0, 0, 1, 0, 32'h0);
    check32("x_flush if_instruction", if_instruction, NOP);
    check32("x_flush if_valid", {31'd0, if_valid}, 32'd0);
    xmode = 1'b0;
    step(0, 0, 0, 0, 32'h0);
    check32("post_x if_pc", if_pc, 32'h84);
    check32("post_x if_instruction", if_instruction, memf(32'h20));

    // Reset dominates a simultaneous branch and freeze.
    step(1, 1, 1, 1, 32'h400);
    check32("rst_dom imem_address", imem_address, 32'h0);
    check32("rst_dom if_valid", {31'd0, if_valid}, 32'd0);
    check32("rst_dom if_pc", if_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
